// File: rtl/uart_1hot_pkg.sv
// Shared types and helpers for the one-hot UART transmitter.
// The state encoding is one-hot so that a single flipped flop is
// detectable (more or fewer than one bit set) and can be recovered from.
package uart_1hot_pkg;

  typedef logic [4:0] state_t;

  localparam state_t IDLE   = 5'b00001;
  localparam state_t START  = 5'b00010;
  localparam state_t DATA   = 5'b00100;
  localparam state_t PARITY = 5'b01000;
  localparam state_t STOP   = 5'b10000;

  // True when exactly one bit of the state vector is set.
  function automatic logic is_onehot(input state_t s);
    return (s != 5'b00000) && ((s & (s - 5'b00001)) == 5'b00000);
  endfunction

endpackage

// File: rtl/onehot5_sreg.sv
// Five-flop one-hot state register. Synchronous reset lands on IDLE.
module onehot5_sreg
  import uart_1hot_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  state_t nxt_state,
  output state_t state
);

  // State register: reset to IDLE, otherwise follow the next-state logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

endmodule

// File: rtl/uart_tx_1hot.sv
// Serial transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, one stop bit. Each bit lasts BAUD_DIV clock cycles.
// TX is a flop loaded from the next state, so the pin changes on the same
// edge as the state register and carries no combinational glitches.
module uart_tx_1hot
  import uart_1hot_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 TX,
  output logic                 busy,
  output logic                 tx_done,
  output state_t               state
);

  localparam int BCW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam int NCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [NCW-1:0] BIT_LAST  = NCW'(DATA_BITS - 1);

  // Parity bit for a payload: even parity by default, inverted for odd.
  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  state_t               nxt_state_s;
  logic                 legal_s;
  logic                 bit_end_s;
  logic [BCW-1:0]       baud_cnt_r;
  logic [BCW-1:0]       baud_cnt_nxt_s;
  logic [NCW-1:0]       bit_cnt_r;
  logic [NCW-1:0]       bit_cnt_nxt_s;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] shift_nxt_s;
  logic                 par_r;
  logic                 par_nxt_s;
  logic                 tx_nxt_s;
  logic                 done_nxt_s;

  onehot5_sreg u_sreg (
    .clk       (clk),
    .rst       (rst),
    .nxt_state (nxt_state_s),
    .state     (state)
  );

  assign legal_s   = is_onehot(state);
  assign bit_end_s = (baud_cnt_r == BAUD_LAST);
  assign busy      = ~state[0];

  // Next-state, shift/parity/bit-count updates and completion strobe.
  always_comb begin
    nxt_state_s   = state;
    shift_nxt_s   = shift_r;
    par_nxt_s     = par_r;
    bit_cnt_nxt_s = bit_cnt_r;
    done_nxt_s    = 1'b0;
    if (!legal_s) begin
      // Corrupted state vector: return to IDLE immediately, no strobe.
      nxt_state_s = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (trmt) begin
            nxt_state_s = START;
            shift_nxt_s = tx_data;
            par_nxt_s   = frame_parity(tx_data);
          end else begin
            nxt_state_s = IDLE;
          end
        end
        START: begin
          if (bit_end_s) begin
            nxt_state_s   = DATA;
            bit_cnt_nxt_s = {NCW{1'b0}};
          end else begin
            nxt_state_s = START;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            shift_nxt_s   = shift_r >> 1;
            bit_cnt_nxt_s = bit_cnt_r + NCW'(1);
            if (bit_cnt_r == BIT_LAST) begin
              nxt_state_s = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              nxt_state_s = DATA;
            end
          end else begin
            nxt_state_s = DATA;
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            nxt_state_s = STOP;
          end else begin
            nxt_state_s = PARITY;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            nxt_state_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            nxt_state_s = STOP;
          end
        end
        default: begin
          nxt_state_s = IDLE;
        end
      endcase
    end
  end

  // Baud counter: parked at zero in IDLE (or on a bad state), wraps each bit.
  always_comb begin
    baud_cnt_nxt_s = baud_cnt_r;
    if ((state == IDLE) || !legal_s || bit_end_s) begin
      baud_cnt_nxt_s = {BCW{1'b0}};
    end else begin
      baud_cnt_nxt_s = baud_cnt_r + BCW'(1);
    end
  end

  // Line level for the state being entered, so TX tracks state cycle-exactly.
  always_comb begin
    tx_nxt_s = 1'b1;
    case (nxt_state_s)
      IDLE:    tx_nxt_s = 1'b1;
      START:   tx_nxt_s = 1'b0;
      DATA:    tx_nxt_s = shift_nxt_s[0];
      PARITY:  tx_nxt_s = par_nxt_s;
      STOP:    tx_nxt_s = 1'b1;
      default: tx_nxt_s = 1'b1;
    endcase
  end

  // Datapath and output flops; reset aborts any frame and idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_r <= {BCW{1'b0}};
      bit_cnt_r  <= {NCW{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      par_r      <= 1'b0;
      TX         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      baud_cnt_r <= baud_cnt_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      par_r      <= par_nxt_s;
      TX         <= tx_nxt_s;
      tx_done    <= done_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_1hot.sv
// Bench for uart_tx_1hot: three instances (even parity, odd parity, no
// parity) share clock and reset. Stimulus pushes the expected frame into a
// per-instance queue; a monitor checks the line cycle by cycle against it.
module tb_uart_tx_1hot;
  import uart_1hot_pkg::*;

  localparam int B  = 4;
  localparam int DB = 8;

  typedef struct {
    logic [11:0] bits;
    int          nbits;
    int          len;
  } frame_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [2:0] trmt = 3'b000;
  logic [7:0] td [3];
  wire  [2:0] tx_o;
  wire  [2:0] busy_o;
  wire  [2:0] done_o;
  wire  [4:0] st_o [3];

  int     checks = 0;
  int     errors = 0;
  bit [2:0] mon_en = 3'b000;
  bit [2:0] act    = 3'b000;
  int     cnt [3];
  frame_t cur [3];
  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];
  bit     pe_a [3] = '{1'b1, 1'b1, 1'b0};
  bit     po_a [3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  uart_tx_1hot #(.BAUD_DIV(B), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst(rst), .trmt(trmt[0]), .tx_data(td[0]), .TX(tx_o[0]),
    .busy(busy_o[0]), .tx_done(done_o[0]), .state(st_o[0]));
  uart_tx_1hot #(.BAUD_DIV(B), .DATA_BITS(DB), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
    .clk(clk), .rst(rst), .trmt(trmt[1]), .tx_data(td[1]), .TX(tx_o[1]),
    .busy(busy_o[1]), .tx_done(done_o[1]), .state(st_o[1]));
  uart_tx_1hot #(.BAUD_DIV(B), .DATA_BITS(DB), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
    .clk(clk), .rst(rst), .trmt(trmt[2]), .tx_data(td[2]), .TX(tx_o[2]),
    .busy(busy_o[2]), .tx_done(done_o[2]), .state(st_o[2]));

  // Reference frame: start 0, data LSB first, optional parity, stop 1.
  function automatic frame_t make_frame(input logic [7:0] d, input bit pe, input bit po);
    frame_t f;
    int n;
    f.bits = 12'h000;
    n = 1;
    for (int j = 0; j < DB; j++) begin
      f.bits[n] = d[j];
      n++;
    end
    if (pe) begin
      f.bits[n] = (^d) ^ po;
      n++;
    end
    f.bits[n] = 1'b1;
    n++;
    f.nbits = n;
    f.len   = n * B;
    return f;
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic frame_t q_front(input int i);
    case (i)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_push(input int i, input frame_t f);
    case (i)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  task automatic q_pop(input int i);
    case (i)
      0:       void'(q0.pop_front());
      1:       void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  task automatic q_clear(input int i);
    case (i)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
  endtask

  task automatic chk(input int i, input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL dut%0d %s got=%0h want=%0h t=%0t", i, nm, a, e, $time);
    end
  endtask

  // Monitor: follows each instance's line and compares against its queue.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || !mon_en[i]) begin
        act[i] = 1'b0;
        q_clear(i);
      end else begin
        if (!act[i]) begin
          chk(i, "idle_no_done", done_o[i], 1'b0);
          if (busy_o[i]) begin
            chk(i, "start_expected", q_size(i) != 0, 1'b1);
            if (q_size(i) != 0) begin
              act[i] = 1'b1;
              cnt[i] = 0;
              cur[i] = q_front(i);
            end
          end
        end
        if (act[i]) begin
          if (cnt[i] < cur[i].len) begin
            chk(i, "tx_bit", tx_o[i], cur[i].bits[cnt[i] / B]);
            chk(i, "busy_in_frame", busy_o[i], 1'b1);
            chk(i, "done_early", done_o[i], 1'b0);
            chk(i, "state_onehot", $onehot(st_o[i]), 1'b1);
            if (!pe_a[i]) chk(i, "no_parity_state", st_o[i] == PARITY, 1'b0);
          end else begin
            chk(i, "done_pulse", done_o[i], 1'b1);
            chk(i, "done_not_busy", busy_o[i], 1'b0);
            chk(i, "tx_idle_high", tx_o[i], 1'b1);
            q_pop(i);
            act[i] = 1'b0;
          end
          cnt[i]++;
        end
      end
    end
  end

  // Issue one frame on instance i once it is idle; called at a negedge.
  task automatic send(input int i, input logic [7:0] d);
    int w;
    w = 0;
    while (busy_o[i] && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk(i, "send_idle_timeout", w < 300, 1'b1);
    td[i]   = d;
    trmt[i] = 1'b1;
    q_push(i, make_frame(d, pe_a[i], po_a[i]));
    @(negedge clk);
    trmt[i] = 1'b0;
    td[i]   = 8'($urandom);
  endtask

  task automatic wait_idle(input int i);
    int w;
    w = 0;
    while ((busy_o[i] || q_size(i) != 0) && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk(i, "wait_idle_timeout", w < 300, 1'b1);
    @(negedge clk);
  endtask

  initial begin
    int w;
    for (int i = 0; i < 3; i++) td[i] = 8'h00;

    // Reset held two cycles with trmt asserted: must stay idle.
    rst  = 1'b1;
    trmt = 3'b111;
    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk(i, "rst_state", st_o[i], IDLE);
        chk(i, "rst_tx", tx_o[i], 1'b1);
        chk(i, "rst_busy", busy_o[i], 1'b0);
        chk(i, "rst_done", done_o[i], 1'b0);
      end
    end
    rst    = 1'b0;
    trmt   = 3'b000;
    mon_en = 3'b111;
    @(negedge clk);

    // Directed frames.
    send(0, 8'hA5);
    wait_idle(0);
    send(1, 8'h01);
    wait_idle(1);
    send(2, 8'hFF);
    td[2] = 8'h00;
    wait_idle(2);

    // Random frames on all three instances concurrently.
    fork
      begin
        for (int n = 0; n < 6; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(0, 8'($urandom));
        end
        wait_idle(0);
      end
      begin
        for (int n = 0; n < 6; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(1, 8'($urandom));
        end
        wait_idle(1);
      end
      begin
        for (int n = 0; n < 6; n++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(2, 8'($urandom));
        end
        wait_idle(2);
      end
    join

    // trmt held high: exactly one idle cycle between frames.
    trmt[0] = 1'b1;
    for (int n = 0; n < 3; n++) begin
      td[0] = 8'($urandom);
      q_push(0, make_frame(td[0], pe_a[0], po_a[0]));
      @(negedge clk);
      chk(0, "b2b_start_after_one_idle", busy_o[0], 1'b1);
      w = 0;
      while (busy_o[0] && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk(0, "b2b_frame_timeout", w < 100, 1'b1);
      chk(0, "b2b_done_with_idle", done_o[0], 1'b1);
    end
    trmt[0] = 1'b0;
    wait_idle(0);

    // Reset in the middle of data bit 3.
    send(0, 8'($urandom));
    repeat (17) @(negedge clk);
    mon_en[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk(0, "abort_state", st_o[0], IDLE);
    chk(0, "abort_tx", tx_o[0], 1'b1);
    chk(0, "abort_busy", busy_o[0], 1'b0);
    chk(0, "abort_done", done_o[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk(0, "abort_no_done_after", done_o[0], 1'b0);
    chk(0, "abort_still_idle", st_o[0], IDLE);
    mon_en = 3'b111;
    @(negedge clk);

    // Illegal state vector injected mid-frame.
    send(0, 8'($urandom));
    repeat (10) @(negedge clk);
    mon_en[0] = 1'b0;
    force dut0.u_sreg.state = 5'b00110;
    @(posedge clk);
    #1;
    chk(0, "illegal_tx_high", tx_o[0], 1'b1);
    chk(0, "illegal_no_done", done_o[0], 1'b0);
    release dut0.u_sreg.state;
    @(posedge clk);
    #1;
    chk(0, "illegal_recover_idle", st_o[0], IDLE);
    chk(0, "illegal_recover_tx", tx_o[0], 1'b1);
    chk(0, "illegal_recover_done", done_o[0], 1'b0);
    @(negedge clk);
    mon_en[0] = 1'b1;
    @(negedge clk);

    // Normal operation after recovery.
    send(0, 8'h3C);
    wait_idle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
